seg_scan_driver: RTL
====================

# seg_scan_driver

Multiplexed seven-segment scan driver that sits directly downstream of the digest output window. It consumes the six 5-bit digit codes produced by the window (bit 4 = control flag, bits 3:0 = hex nibble), snapshots them once per frame to prevent tearing, and time-multiplexes them onto a common-cathode-bus, per-digit-anode display. The driver applies a dead-time blanking interval at the start of each digit slot to suppress ghosting.

## Interface
Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 64, anode-off cycles at the start of each slot; legal range 1 ≤ BLANK_CYCLES < SCAN_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- code0..code5  in  5 each  digit codes. code0 is the least-significant (rightmost) digit.
- hold  in  1  when 1, frame-boundary snapshots are suppressed.
- an  out  6  active-low anodes; an[n] drives the digit showing code n.
- seg_n  out  7  active-low cathodes {g,f,e,d,c,b,a}.
- frame_done  out  1  one-cycle pulse on every snapshot load.

## Operation
- **Prescaler `presc`:** counts 0..SCAN_DIV-1 and wraps to 0.
- **Digit index `idx`:** 0..5. Advances when presc == SCAN_DIV-1. Wraps from 5 to 0.
- **Snapshot register `snap[0..5]`:**
  - Reset value is 5'b10000 for every digit.
  - Loads all six codes on a load event, but only when hold == 0.
  - A load event is either of:
    - (presc == SCAN_DIV-1 && idx == 5), or
    - the first clock edge after reset deasserts, tracked by an internal `first` flag that reset sets and that clears on that edge.
  - frame_done = 1 in the cycle after any load event for which hold == 0. Otherwise it is 0.
- **Code decode (active-low):**
  - 0_xxxx decodes to the standard hex glyph:
    - 0 = 1000000
    - 1 = 1111001
    - 8 = 0000000
    - A = 0001000
    - F = 0001110
  - 1_1111 decodes to a dash (end-of-data marker): 0111111.
  - Any other 1_xxxx decodes to blank: 1111111.
- **Output register:** an and seg_n are registered. At each edge they are computed from the pre-edge presc, idx and snap:
  - presc < BLANK_CYCLES: an = 6'b111111, seg_n = 7'h7F.
  - Otherwise: an = ~(6'b1 << idx), seg_n = decode(snap[idx]).
- **hold:** sampled only at load events. Changes between load events have no effect. Scanning continues regardless of hold.
- **Reset (asynchronous, immediate):**
  - presc = 0, idx = 0, snap = all blank, first = 1.
  - an = 6'b111111, seg_n = 7'h7F, frame_done = 0.
  - Reset asserted mid-slot or mid-frame blanks the display at once.
  - After release, the driver restarts from slot 0.

## Timing
- Frame period is 6*SCAN_DIV cycles. frame_done repeats at that period while hold == 0.
- Output latency: one cycle from counter state to an/seg_n.
- Snapshot latency:
  - An input change is displayed at the next frame boundary.
  - The first lit cycle of slot 0 appears BLANK_CYCLES+1 edges after the boundary edge.
- Post-reset sequence:
  - Edge 0 (first edge with rst low): snapshot loads; frame_done = 1 after the edge.
  - Edges 0..BLANK_CYCLES-1: an is all off.
  - Edge BLANK_CYCLES: an = 6'b111110.
- Each digit is lit for exactly SCAN_DIV-BLANK_CYCLES cycles per slot. No two anodes are ever low together.
- Simultaneous load event and hold = 1: no load and no frame_done; the old snapshot is kept and the counters wrap normally.

## Test plan
All scenarios use SCAN_DIV=8 and BLANK_CYCLES=2.
- **Reset values:** assert rst asynchronously between edges → an = 111111, seg_n = 7F and frame_done = 0 immediately, before the next edge.
- **Decode and scan order:** codes {5'h00, 01, 08, 0F, 1F, 10} on code0..5, release reset → frame_done pulses after edge 0. Each slot shows 2 dark cycles then 6 lit cycles:
  - slot 0: an = 111110, seg_n = 1000000
  - slot 1: an = 111101, seg_n = 1111001
  - slot 2: an = 111011, seg_n = 0000000
  - slot 3: an = 110111, seg_n = 0001110
  - slot 4: an = 101111, seg_n = 0111111
  - slot 5: an = 011111, seg_n = 1111111
- **Snapshot isolation:** change code0 to 5'h0A mid-frame → the displayed slot-0 value is unchanged until the frame boundary, then shows 0001000. frame_done is spaced exactly 48 cycles.
- **Hold:** hold = 1 across a boundary while code0 changes → no frame_done and the old glyph is kept. Release hold → the new glyph appears after the next boundary.
- **Reset mid-operation:** assert rst during slot 3's lit phase → blank immediately. After release, the driver restarts at slot 0 with a fresh snapshot.
- **Anode exclusivity:** random codes and random hold for 10 frames → an never has more than one 0 bit. The checker asserts this on every cycle.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed six-digit seven-segment scan driver.
// Snapshots the six incoming digit codes once per frame so a digit never
// changes part-way through a frame, then scans them one slot at a time with
// a dark interval at the start of each slot to keep the previous digit's
// glyph from ghosting onto the next anode.

module seg_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] code0,
    input  logic [4:0] code1,
    input  logic [4:0] code2,
    input  logic [4:0] code3,
    input  logic [4:0] code4,
    input  logic [4:0] code5,
    input  logic       hold,
    output logic [5:0] an,
    output logic [6:0] seg_n,
    output logic       frame_done
);

    localparam int              PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]   BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [4:0]      CODE_BLANK = 5'b10000;

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [4:0]    snap [6];
    logic          first;

    logic [4:0]    codes_in [6];
    logic          slot_end;
    logic          frame_end;
    logic          load_now;
    logic [4:0]    cur_code;
    logic [6:0]    cur_glyph;

    // Active-low glyph for one digit code: hex digits, dash marker, or blank.
    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] g;
        g = 7'h7F;
        if (code[4]) begin
            g = (code[3:0] == 4'hF) ? 7'h3F : 7'h7F;
        end else begin
            case (code[3:0])
                4'h0: g = 7'b1000000;
                4'h1: g = 7'b1111001;
                4'h2: g = 7'b0100100;
                4'h3: g = 7'b0110000;
                4'h4: g = 7'b0011001;
                4'h5: g = 7'b0010010;
                4'h6: g = 7'b0000010;
                4'h7: g = 7'b1111000;
                4'h8: g = 7'b0000000;
                4'h9: g = 7'b0010000;
                4'hA: g = 7'b0001000;
                4'hB: g = 7'b0000011;
                4'hC: g = 7'b1000110;
                4'hD: g = 7'b0100001;
                4'hE: g = 7'b0000110;
                default: g = 7'b0001110;
            endcase
        end
        return g;
    endfunction

    assign codes_in[0] = code0;
    assign codes_in[1] = code1;
    assign codes_in[2] = code2;
    assign codes_in[3] = code3;
    assign codes_in[4] = code4;
    assign codes_in[5] = code5;

    // Slot/frame boundaries, the snapshot load decision and the current digit glyph.
    always_comb begin
        slot_end  = (presc == PRESC_LAST);
        frame_end = slot_end && (idx == 3'd5);
        load_now  = (frame_end || first) && !hold;
        case (idx)
            3'd0:    cur_code = snap[0];
            3'd1:    cur_code = snap[1];
            3'd2:    cur_code = snap[2];
            3'd3:    cur_code = snap[3];
            3'd4:    cur_code = snap[4];
            3'd5:    cur_code = snap[5];
            default: cur_code = CODE_BLANK;
        endcase
        cur_glyph = decode(cur_code);
    end

    // Prescaler and digit index: idx steps once per SCAN_DIV cycles, 0..5.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= 3'd0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Marks the first edge out of reset so the display gets a snapshot right away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first <= 1'b1;
        end else begin
            first <= 1'b0;
        end
    end

    // Frame snapshot; hold only matters at the instant a load would happen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                snap[i] <= CODE_BLANK;
            end
            frame_done <= 1'b0;
        end else begin
            if (load_now) begin
                for (int i = 0; i < 6; i++) begin
                    snap[i] <= codes_in[i];
                end
            end
            frame_done <= load_now;
        end
    end

    // Registered display drive: dark during the dead-time, then one anode lit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an    <= 6'b111111;
            seg_n <= 7'h7F;
        end else if (presc < BLANK_END) begin
            an    <= 6'b111111;
            seg_n <= 7'h7F;
        end else begin
            an    <= ~(6'b000001 << idx);
            seg_n <= cur_glyph;
        end
    end

endmodule
